// File: rtl/profile_seq_if.sv
// Host command channel into the profile_seq FIFO: one 64-bit param write per entry,
// with a "last" flag and tick count closing a segment.
interface profile_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [63:0] cmd_data;
  logic        cmd_last;
  logic [31:0] cmd_ticks;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_last, cmd_ticks,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_last, cmd_ticks,
    output cmd_ready
  );
endinterface

// File: rtl/profile_seq.sv
// Segment sequencer for profile_gen: queues param writes, loads each segment as lo/hi
// 32-bit writes, then issues acc_step at a programmable tick rate for the segment length.
module profile_seq #(
  parameter int unsigned Depth = 16,
  parameter int unsigned DivW  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  profile_seq_if.slave             cmd,
  input  logic [DivW-1:0]          tick_div_i,
  input  logic                     enable_i,
  input  logic                     abort_i,
  input  logic                     pg_busy_i,
  output logic                     acc_step_o,
  output logic [7:0]               param_addr_o,
  output logic [31:0]              param_in_o,
  output logic                     param_write_lo_o,
  output logic                     param_write_hi_o,
  output logic                     running_o,
  output logic [31:0]              ticks_left_o,
  output logic [$clog2(Depth):0]   fifo_level_o,
  output logic                     overrun_o,
  output logic                     underrun_o
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] DepthL = Depth[AddrW:0];

  typedef struct packed {
    logic        last;
    logic [31:0] ticks;
    logic [7:0]  addr;
    logic [63:0] data;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StRun} state_e;

  entry_t           mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d, last_cnt_q, last_cnt_d;
  state_e           state_q, state_d;
  logic [31:0]      ticks_q, ticks_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             pend_q, pend_d, ovr_q, ovr_d, und_q, und_d;
  logic             wlo_q, wlo_d, whi_q, whi_d;
  logic [7:0]       paddr_q, paddr_d;
  logic [31:0]      pin_q, pin_d;
  logic             push, pop, fire;
  entry_t           head, out_ent;

  assign cmd.cmd_ready = (count_q != DepthL);
  assign push = cmd.cmd_valid && cmd.cmd_ready && !abort_i;
  assign head = mem_q[rd_ptr_q];
  // Entry presented on the param bus next cycle: head after any pop this cycle.
  assign out_ent = mem_q[rd_ptr_d];

  always_comb begin
    state_d = state_q;
    ticks_d = ticks_q;
    div_d   = div_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    und_d   = und_q;
    pop     = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: if (last_cnt_q != '0 && !pg_busy_i) state_d = StLo;
      StLo:   state_d = StHi;
      StHi: begin
        pop = 1'b1;
        if (head.last) begin
          ticks_d = head.ticks;
          div_d   = '0;
          pend_d  = 1'b0;
          state_d = (head.ticks == '0) ? StIdle : StRun;
        end else begin
          state_d = StLo;
        end
      end
      StRun: begin
        if (enable_i) begin
          if (pend_q || div_q == tick_div_i) begin
            div_d = '0;
            if (pg_busy_i) begin
              pend_d = 1'b1;
              ovr_d  = 1'b1;
            end else begin
              pend_d = 1'b0;
              fire   = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (fire) begin
      if (ticks_q <= 32'd1) begin
        ticks_d = '0;
        state_d = StIdle;
        if (last_cnt_q == '0) und_d = 1'b1;
      end else begin
        ticks_d = ticks_q - 32'd1;
      end
    end

    if (abort_i) begin
      state_d = StIdle;
      ticks_d = '0;
      div_d   = '0;
      pend_d  = 1'b0;
      pop     = 1'b0;
    end

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    last_cnt_d = last_cnt_q;
    if (push && cmd.cmd_last) last_cnt_d = last_cnt_d + 1'b1;
    if (pop && head.last)     last_cnt_d = last_cnt_d - 1'b1;
    if (abort_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      last_cnt_d = '0;
    end

    wlo_d   = (state_d == StLo);
    whi_d   = (state_d == StHi);
    paddr_d = (wlo_d || whi_d) ? out_ent.addr : 8'h00;
    pin_d   = wlo_d ? out_ent.data[31:0] : (whi_d ? out_ent.data[63:32] : 32'h0);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{last: cmd.cmd_last, ticks: cmd.cmd_ticks,
                                   addr: cmd.cmd_addr, data: cmd.cmd_data};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_cnt_q <= '0;
      state_q    <= StIdle;
      ticks_q    <= '0;
      div_q      <= '0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      wlo_q      <= 1'b0;
      whi_q      <= 1'b0;
      paddr_q    <= '0;
      pin_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_cnt_q <= last_cnt_d;
      state_q    <= state_d;
      ticks_q    <= ticks_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
      wlo_q      <= wlo_d;
      whi_q      <= whi_d;
      paddr_q    <= paddr_d;
      pin_q      <= pin_d;
    end
  end

  assign acc_step_o       = fire && !abort_i;
  assign param_addr_o     = paddr_q;
  assign param_in_o       = pin_q;
  assign param_write_lo_o = wlo_q;
  assign param_write_hi_o = whi_q;
  assign running_o        = (state_q == StRun);
  assign ticks_left_o     = ticks_q;
  assign fifo_level_o     = count_q;
  assign overrun_o        = ovr_q;
  assign underrun_o       = und_q;
endmodule

// File: tb/tb_profile_seq.sv
// Directed bench for profile_seq: a per-cycle vector table for a full segment,
// plus hand-written sequences for chaining, busy deferral, full FIFO, abort and reset.
module tb_profile_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tick_div = 8'd2;
  logic        enable = 1'b1;
  logic        abort = 1'b0;
  logic        pg_busy = 1'b0;
  logic        acc_step, wlo, whi, running, overrun, underrun;
  logic [7:0]  param_addr;
  logic [31:0] param_in, ticks_left;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  profile_seq_if cif ();

  profile_seq #(.Depth(4), .DivW(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cmd             (cif),
    .tick_div_i      (tick_div),
    .enable_i        (enable),
    .abort_i         (abort),
    .pg_busy_i       (pg_busy),
    .acc_step_o      (acc_step),
    .param_addr_o    (param_addr),
    .param_in_o      (param_in),
    .param_write_lo_o(wlo),
    .param_write_hi_o(whi),
    .running_o       (running),
    .ticks_left_o    (ticks_left),
    .fifo_level_o    (fifo_level),
    .overrun_o       (overrun),
    .underrun_o      (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        vld, last;
    logic [7:0]  addr;
    logic [63:0] data;
    logic [31:0] ticks;
    logic        wlo, whi;
    logic [7:0]  paddr;
    logic [31:0] pin;
    logic        acc, run;
    logic [31:0] tleft;
    logic [2:0]  level;
    logic        und;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic last, input logic [7:0] a,
                              input logic [63:0] d, input logic [31:0] t, input logic lo,
                              input logic hi, input logic [7:0] pa, input logic [31:0] pi,
                              input logic acc, input logic run, input logic [31:0] tl,
                              input logic [2:0] lv, input logic und);
    vec_t v;
    v.vld = vld; v.last = last; v.addr = a; v.data = d; v.ticks = t;
    v.wlo = lo; v.whi = hi; v.paddr = pa; v.pin = pi; v.acc = acc; v.run = run;
    v.tleft = tl; v.level = lv; v.und = und;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [63:0] d, input logic l,
                      input logic [31:0] t);
    cif.cmd_valid = 1'b1; cif.cmd_addr = a; cif.cmd_data = d;
    cif.cmd_last = l; cif.cmd_ticks = t;
    step();
    cif.cmd_valid = 1'b0;
  endtask

  function automatic logic [95:0] outs();
    return {16'h0, wlo, whi, param_addr, param_in, acc_step, running, ticks_left,
            fifo_level, underrun};
  endfunction

  task automatic wait_running(input string name);
    int k;
    for (k = 0; k < 30; k++) begin
      if (running) break;
      step();
    end
    if (!running) begin
      n_checks++; n_errors++;
      $display("FAIL %s: running never rose (got 0 expected 1)", name);
    end
  endtask

  vec_t tbl[22];

  initial begin
    int acc_n, lo_n, overlap, wr_n;
    int lo_acc[4];
    cif.cmd_valid = 1'b0; cif.cmd_addr = '0; cif.cmd_data = '0;
    cif.cmd_last = 1'b0; cif.cmd_ticks = '0;

    tbl[0]  = mk(1, 0, 8'h01, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 8'h22, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    tbl[2]  = mk(1, 1, 8'h43, 64'h0123_4567_89AB_CDEF, 4, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 8'h01, 32'h3333_4444, 0, 0, 0, 3, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h01, 32'h1111_2222, 0, 0, 0, 3, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 8'h22, 32'hCCCC_DDDD, 0, 0, 0, 2, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h22, 32'hAAAA_BBBB, 0, 0, 0, 2, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 8'h43, 32'h89AB_CDEF, 0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h43, 32'h0123_4567, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset state
    step(); step();
    check("reset_outputs", {outs(), overrun, cif.cmd_ready}, {96'h0, 1'b0, 1'b1});
    rst = 1'b0;

    // Test 1: three-entry segment, ticks=4, tick_div=2
    for (int i = 0; i < 22; i++) begin
      cif.cmd_valid = tbl[i].vld; cif.cmd_last = tbl[i].last; cif.cmd_addr = tbl[i].addr;
      cif.cmd_data = tbl[i].data; cif.cmd_ticks = tbl[i].ticks;
      step();
      check($sformatf("seg1_row%0d", i), outs(),
            {16'h0, tbl[i].wlo, tbl[i].whi, tbl[i].paddr, tbl[i].pin, tbl[i].acc,
             tbl[i].run, tbl[i].tleft, tbl[i].level, tbl[i].und});
    end
    cif.cmd_valid = 1'b0;

    // Test 6: reset lands while the lo half is on the bus; hi half must never appear
    push(8'h55, 64'h0, 1'b1, 32'd2);
    for (int k = 0; k < 10 && !wlo; k++) step();
    check("pre_rst_write_lo", {95'h0, wlo}, 96'h1);
    rst = 1'b1;
    step();
    check("rst_mid_load", {outs(), overrun, cif.cmd_ready}, {96'h0, 1'b0, 1'b1});
    rst = 1'b0;
    step();
    check("rst_no_write_hi", {94'h0, whi, wlo}, 96'h0);

    // Test 2: two one-entry segments, ticks=2 each, tick_div=0
    tick_div = 8'd0;
    acc_n = 0; lo_n = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 2) begin
        cif.cmd_valid = 1'b1; cif.cmd_last = 1'b1; cif.cmd_ticks = 32'd2;
        cif.cmd_addr = (i == 0) ? 8'h10 : 8'h20; cif.cmd_data = 64'h0;
      end else begin
        cif.cmd_valid = 1'b0;
      end
      step();
      if (acc_step && (wlo || whi)) overlap++;
      if (wlo && lo_n < 4) begin
        lo_acc[lo_n] = acc_n;
        lo_n++;
      end
      if (acc_step) acc_n++;
    end
    check("seg2_lo_count", 96'(lo_n), 96'd2);
    check("seg2_first_lo_before_ticks", 96'(lo_acc[0]), 96'd0);
    check("seg2_second_lo_after_2nd_tick", 96'(lo_acc[1]), 96'd2);
    check("seg2_overlap", 96'(overlap), 96'd0);
    check("seg2_acc_total", 96'(acc_n), 96'd4);

    // Test 3: pg_busy held across a due tick
    tick_div = 8'd1;
    check("ovr_clear_before_busy", {95'h0, overrun}, 96'h0);
    push(8'h05, 64'h0, 1'b1, 32'd3);
    wait_running("busy_start");
    pg_busy = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (acc_step) acc_n++;
    end
    check("no_acc_while_busy", 96'(acc_n), 96'd0);
    check("overrun_set", {95'h0, overrun}, 96'h1);
    pg_busy = 1'b0;
    #1;
    check("deferred_acc_on_release", {95'h0, acc_step}, 96'h1);
    acc_n = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (acc_step) acc_n++;
      if (!running) break;
    end
    check("busy_acc_total", 96'(acc_n), 96'd3);
    check("busy_end_idle", {63'h0, running, ticks_left}, 96'h0);

    // Test 4: fill FIFO with no last entry
    wr_n = 0;
    for (int i = 0; i < 4; i++) begin
      push(8'(i), 64'(i), 1'b0, 32'd0);
      if (wlo || whi) wr_n++;
    end
    check("full_ready_level", {92'h0, cif.cmd_ready, fifo_level}, {92'h0, 1'b0, 3'd4});
    push(8'hEE, 64'h0, 1'b1, 32'd1);
    if (wlo || whi) wr_n++;
    check("push_when_full_ignored", {93'h0, fifo_level}, 96'd4);
    check("full_no_writes", 96'(wr_n), 96'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_empties", {92'h0, cif.cmd_ready, fifo_level}, {92'h0, 1'b1, 3'd0});
    push(8'h77, 64'hDEAD_BEEF_0000_0001, 1'b1, 32'd1);
    check("refill_level", {93'h0, fifo_level}, 96'd1);
    step();
    check("refill_write_lo", {55'h0, wlo, param_addr, param_in},
          {55'h0, 1'b1, 8'h77, 32'h0000_0001});
    for (int i = 0; i < 10; i++) step();

    // Test 5: abort while running with two segments queued
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick_div = 8'd3;
    push(8'h31, 64'h0, 1'b1, 32'd5);
    push(8'h32, 64'h0, 1'b1, 32'd2);
    push(8'h33, 64'h0, 1'b1, 32'd2);
    wait_running("abort_start");
    step(); step();
    check("abort_pre_level", {93'h0, fifo_level}, 96'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_run_state", {60'h0, acc_step, running, ticks_left, fifo_level},
          96'h0);
    wr_n = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (acc_step || wlo || whi) wr_n++;
    end
    check("abort_quiet_after", 96'(wr_n), 96'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
